// File: rtl/mvb_frame_rx.sv
// ============================================================================
// Module      : mvb_frame_rx
// Description : MVB Manchester frame receiver. Synchronises the serial line,
//               recovers half-bit samples, detects the master/slave start
//               delimiter, decodes 16/32/64 data bits into 16-bit words and
//               consumes the 8-bit check sequence.
//               Optional macro MVB_RX_CRC_EN enables CRC-7 + parity checking
//               of the check sequence (crc_err stays 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvb_frame_rx (
  input  logic        clk_24M,
  input  logic        RESET,
  input  logic        line_in,
  input  logic [1:0]  frame_bits,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        is_master,
  output logic        frame_done,
  output logic        manch_err,
  output logic        crc_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELIM = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_END   = 3'd4
  } state_t;

  localparam logic [17:0] DELIM_MASTER = 18'b101011000111000101;
  localparam logic [17:0] DELIM_SLAVE  = 18'b100101011100011100;
  // A legal 3-half-bit run puts its next edge exactly 24 cycles later, so
  // only the absence of that edge is a timeout.
  localparam logic [4:0]  QUIET_LIMIT  = 5'd23;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  quiet_q, quiet_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [17:0] dshift_q, dshift_d;
  logic        half_q, half_d;
  logic        first_q, first_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] wshift_q, wshift_d;
  logic [15:0] word_out_q, word_out_d;
  logic        word_valid_q, word_valid_d;
  logic        is_master_q, is_master_d;
  logic        frame_done_q, frame_done_d;
  logic        manch_err_q, manch_err_d;
  logic        crc_err_q, crc_err_d;
  logic        busy_q, busy_d;
`ifdef MVB_RX_CRC_EN
  logic [6:0]  crc_q, crc_d;
  logic        par_q, par_d;
  logic [6:0]  chk_q, chk_d;
  logic        crc_fb;
`endif

  logic        line_edge, line_rise, sample, timeout, data_bit;
  logic [2:0]  cnt_eff;
  logic [5:0]  last_bit;

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign is_master  = is_master_q;
  assign frame_done = frame_done_q;
  assign manch_err  = manch_err_q;
  assign crc_err    = crc_err_q;
  assign busy       = busy_q;

  // Synchroniser, half-bit sampling counter and edge-silence timer.
  always_comb begin
    sync1_d   = line_in;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    line_edge = sync2_q ^ sync3_q;
    line_rise = sync2_q & ~sync3_q;
    cnt_eff   = line_edge ? 3'd0 : cnt_q;
    sample    = (cnt_eff == 3'd3);
    cnt_d     = cnt_eff + 3'd1;
    quiet_d   = line_edge ? 5'd0 : ((quiet_q == 5'd31) ? quiet_q : quiet_q + 5'd1);
    timeout   = !line_edge && (quiet_q >= QUIET_LIMIT);
    data_bit  = first_q;
    case (frame_bits)
      2'd0:    last_bit = 6'd15;
      2'd1:    last_bit = 6'd31;
      default: last_bit = 6'd63;
    endcase
  end

  // Frame FSM: next state, shifters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    dshift_d     = dshift_q;
    half_d       = half_q;
    first_d      = first_q;
    bit_cnt_d    = bit_cnt_q;
    wshift_d     = wshift_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    is_master_d  = is_master_q;
    frame_done_d = 1'b0;
    manch_err_d  = manch_err_q;
    crc_err_d    = crc_err_q;
`ifdef MVB_RX_CRC_EN
    crc_d        = crc_q;
    par_d        = par_q;
    chk_d        = chk_q;
    crc_fb       = crc_q[6] ^ data_bit;
`endif
    case (state_q)
      S_IDLE: begin
        if (line_rise) begin
          state_d     = S_DELIM;
          manch_err_d = 1'b0;
          crc_err_d   = 1'b0;
          dcnt_d      = 5'd0;
          dshift_d    = 18'd0;
        end
      end
      S_DELIM: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (sample) begin
          dshift_d = {dshift_q[16:0], sync2_q};
          dcnt_d   = dcnt_q + 5'd1;
          if (dcnt_q == 5'd17) begin
            half_d    = 1'b0;
            bit_cnt_d = 6'd0;
`ifdef MVB_RX_CRC_EN
            crc_d     = 7'd0;
            par_d     = 1'b0;
`endif
            if ({dshift_q[16:0], sync2_q} == DELIM_MASTER) begin
              is_master_d = 1'b1;
              state_d     = S_DATA;
            end else if ({dshift_q[16:0], sync2_q} == DELIM_SLAVE) begin
              is_master_d = 1'b0;
              state_d     = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DATA, S_CHECK: begin
        if (timeout) begin
          manch_err_d = 1'b1;
          state_d     = S_END;
        end else if (sample) begin
          if (!half_q) begin
            first_d = sync2_q;
            half_d  = 1'b1;
          end else begin
            half_d = 1'b0;
            if (first_q == sync2_q) begin
              manch_err_d = 1'b1;
              state_d     = S_END;
            end else if (state_q == S_DATA) begin
              wshift_d  = {wshift_q[14:0], data_bit};
              bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef MVB_RX_CRC_EN
              crc_d     = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h65 : 7'h00);
              par_d     = par_q ^ data_bit;
`endif
              if (bit_cnt_q[3:0] == 4'hF) begin
                word_out_d   = {wshift_q[14:0], data_bit};
                word_valid_d = 1'b1;
              end
              if (bit_cnt_q == last_bit) begin
                bit_cnt_d = 6'd0;
                state_d   = S_CHECK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef MVB_RX_CRC_EN
              chk_d     = {chk_q[5:0], data_bit};
`endif
              if (bit_cnt_q == 6'd7) begin
                state_d = S_END;
`ifdef MVB_RX_CRC_EN
                crc_err_d = ({chk_q, data_bit} != ~{crc_q, par_q ^ (^crc_q)});
`endif
              end
            end
          end
        end
      end
      S_END: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk_24M) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      cnt_q        <= 3'd0;
      quiet_q      <= 5'd0;
      dcnt_q       <= 5'd0;
      dshift_q     <= 18'd0;
      half_q       <= 1'b0;
      first_q      <= 1'b0;
      bit_cnt_q    <= 6'd0;
      wshift_q     <= 16'd0;
      word_out_q   <= 16'h0000;
      word_valid_q <= 1'b0;
      is_master_q  <= 1'b0;
      frame_done_q <= 1'b0;
      manch_err_q  <= 1'b0;
      crc_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MVB_RX_CRC_EN
      crc_q        <= 7'd0;
      par_q        <= 1'b0;
      chk_q        <= 7'd0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      cnt_q        <= cnt_d;
      quiet_q      <= quiet_d;
      dcnt_q       <= dcnt_d;
      dshift_q     <= dshift_d;
      half_q       <= half_d;
      first_q      <= first_d;
      bit_cnt_q    <= bit_cnt_d;
      wshift_q     <= wshift_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      is_master_q  <= is_master_d;
      frame_done_q <= frame_done_d;
      manch_err_q  <= manch_err_d;
      crc_err_q    <= crc_err_d;
      busy_q       <= busy_d;
`ifdef MVB_RX_CRC_EN
      crc_q        <= crc_d;
      par_q        <= par_d;
      chk_q        <= chk_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mvb_frame_rx.sv
// ============================================================================
// Module      : tb_mvb_frame_rx
// Description : Directed scoreboard bench for mvb_frame_rx. Honours
//               MVB_RX_CRC_EN for the expected crc_err of a corrupted
//               check byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvb_frame_rx;

  localparam logic [17:0] TB_DELIM_M = 18'b101011000111000101;
  localparam logic [17:0] TB_DELIM_S = 18'b100101011100011100;

  logic        clk_24M = 1'b0;
  logic        RESET = 1'b0;
  logic        line_in = 1'b0;
  logic [1:0]  frame_bits = 2'd0;
  logic [15:0] word_out;
  logic        word_valid, is_master, frame_done, manch_err, crc_err, busy;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  int          fd_count = 0;
  logic        fd_master = 1'b0, fd_manch = 1'b0, fd_crc = 1'b0;
`ifdef MVB_RX_CRC_EN
  localparam logic EXP_FLIP_CRC = 1'b1;
`else
  localparam logic EXP_FLIP_CRC = 1'b0;
`endif

  always #5 clk_24M = ~clk_24M;

  mvb_frame_rx dut (
    .clk_24M   (clk_24M),
    .RESET     (RESET),
    .line_in   (line_in),
    .frame_bits(frame_bits),
    .word_out  (word_out),
    .word_valid(word_valid),
    .is_master (is_master),
    .frame_done(frame_done),
    .manch_err (manch_err),
    .crc_err   (crc_err),
    .busy      (busy)
  );

  // Scoreboard: compare every emitted word against the queue; capture flags at frame_done.
  always @(negedge clk_24M) begin
    if (word_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %h, no word expected", word_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (word_out !== exp_w) begin
          errors++;
          $display("FAIL word_value: got %h, expected %h", word_out, exp_w);
        end
      end
    end
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_master = is_master;
      fd_manch  = manch_err;
      fd_crc    = crc_err;
    end
  end

  function automatic logic [7:0] check_byte(input logic [15:0] w[4], input int nw);
    logic [6:0] c;
    logic       p, b, fb;
    c = 7'd0;
    p = 1'b0;
    for (int k = 0; k < nw; k++) begin
      for (int i = 15; i >= 0; i--) begin
        b  = w[k][i];
        p  = p ^ b;
        fb = c[6] ^ b;
        c  = {c[5:0], 1'b0};
        if (fb) c = c ^ 7'h65;
      end
    end
    p = p ^ (^c);
    return ~{c, p};
  endfunction

  task automatic send_frame(input logic master, input logic [15:0] w[4], input int nw,
                            input int bad_delim, input int hh_bit, input int flip_chk);
    logic        hb[$];
    logic [17:0] dp;
    logic [7:0]  cb;
    int          n;
    dp = master ? TB_DELIM_M : TB_DELIM_S;
    for (int i = 0; i < 4; i++) hb.push_back(1'b0);
    for (int i = 0; i < 18; i++) hb.push_back((i == bad_delim) ? ~dp[17-i] : dp[17-i]);
    n = 0;
    for (int k = 0; k < nw; k++) begin
      for (int i = 15; i >= 0; i--) begin
        if (n == hh_bit) begin
          hb.push_back(1'b1);
          hb.push_back(1'b1);
        end else begin
          hb.push_back(w[k][i]);
          hb.push_back(~w[k][i]);
        end
        n++;
      end
    end
    cb = check_byte(w, nw);
    if (flip_chk >= 0) cb[flip_chk] = ~cb[flip_chk];
    for (int i = 7; i >= 0; i--) begin
      hb.push_back(cb[i]);
      hb.push_back(~cb[i]);
    end
    for (int i = 0; i < 4; i++) hb.push_back(1'b0);
    @(negedge clk_24M);
    foreach (hb[i]) begin
      line_in = hb[i];
      repeat (8) @(negedge clk_24M);
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24M);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk_24M);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge clk_24M);
    checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL rst_word_out: got %h, expected 0000", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid: got %b, expected 0", word_valid); end
    checks++; if (is_master !== 1'b0) begin errors++; $display("FAIL rst_is_master: got %b, expected 0", is_master); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
    checks++; if (manch_err !== 1'b0) begin errors++; $display("FAIL rst_manch_err: got %b, expected 0", manch_err); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL rst_crc_err: got %b, expected 0", crc_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    RESET = 1'b1;
    repeat (4) @(negedge clk_24M);
  endtask

  task automatic run_frame(input string name, input logic master, input logic [1:0] fb,
                           input logic [15:0] w[4], input int nw, input int nexp,
                           input int bad_delim, input int hh_bit, input int flip_chk,
                           input int exp_fd, input logic exp_manch, input logic exp_crc);
    int   fd0;
    logic ok;
    frame_bits = fb;
    fd0 = fd_count;
    for (int k = 0; k < nexp; k++) exp_q.push_back(w[k]);
    send_frame(master, w, nw, bad_delim, hh_bit, flip_chk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_idle_timeout: busy=%b, expected 0", name, busy); end
    checks++; if (fd_count - fd0 !== exp_fd) begin errors++; $display("FAIL %s_frame_done: got %0d pulses, expected %0d", name, fd_count - fd0, exp_fd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_words_missing: got %0d pending, expected 0", name, exp_q.size()); end
    exp_q.delete();
    if (exp_fd != 0) begin
      checks++; if (fd_master !== master) begin errors++; $display("FAIL %s_is_master: got %b, expected %b", name, fd_master, master); end
      checks++; if (fd_manch !== exp_manch) begin errors++; $display("FAIL %s_manch_err: got %b, expected %b", name, fd_manch, exp_manch); end
      checks++; if (fd_crc !== exp_crc) begin errors++; $display("FAIL %s_crc_err: got %b, expected %b", name, fd_crc, exp_crc); end
    end
  endtask

  task automatic test_master16();
    logic [15:0] w[4] = '{16'h7EC3, 16'h0, 16'h0, 16'h0};
    run_frame("master16", 1'b1, 2'd0, w, 1, 1, -1, -1, -1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_slave64();
    logic [15:0] w[4] = '{16'h7EC3, 16'h7EC4, 16'h7EC5, 16'h7EC6};
    run_frame("slave64", 1'b0, 2'd2, w, 4, 4, -1, -1, -1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_crc_flip();
    logic [15:0] w[4] = '{16'h7EC3, 16'h0, 16'h0, 16'h0};
    run_frame("crcflip", 1'b1, 2'd0, w, 1, 1, -1, -1, 3, 1, 1'b0, EXP_FLIP_CRC);
  endtask

  task automatic test_manch();
    logic [15:0] w[4] = '{16'h7EC3, 16'h0, 16'h0, 16'h0};
    run_frame("manch", 1'b1, 2'd0, w, 1, 0, -1, 5, -1, 1, 1'b1, 1'b0);
  endtask

  task automatic test_bad_delim();
    logic [15:0] w[4] = '{16'h7EC3, 16'h0, 16'h0, 16'h0};
    logic [15:0] v[4] = '{16'h1234, 16'hA5F0, 16'h0, 16'h0};
    run_frame("baddelim", 1'b1, 2'd0, w, 1, 0, 9, -1, -1, 0, 1'b0, 1'b0);
    run_frame("afterbad", 1'b0, 2'd1, v, 2, 2, -1, -1, -1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[4] = '{16'h7EC3, 16'h7EC4, 16'h0, 16'h0};
    logic [15:0] v[4] = '{16'h7EC5, 16'h7EC6, 16'h0, 16'h0};
    int   fd0;
    logic ok;
    frame_bits = 2'd1;
    fd0 = fd_count;
    exp_q.push_back(w[0]);
    fork
      send_frame(1'b1, w, 2, -1, -1, -1);
      begin
        @(negedge clk_24M);
        repeat (500) @(negedge clk_24M);
        RESET = 1'b0;
        @(negedge clk_24M);
        RESET = 1'b1;
        checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL midrst_word_out: got %h, expected 0000", word_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        checks++; if (is_master !== 1'b0) begin errors++; $display("FAIL midrst_is_master: got %b, expected 0", is_master); end
        checks++; if ({word_valid, frame_done, manch_err, crc_err} !== 4'b0000) begin
          errors++; $display("FAIL midrst_flags: got %b, expected 0000", {word_valid, frame_done, manch_err, crc_err});
        end
      end
    join
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_idle_timeout: busy=%b, expected 0", busy); end
    checks++; if (fd_count !== fd0) begin errors++; $display("FAIL midrst_frame_done: got %0d pulses, expected 0", fd_count - fd0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_words_missing: got %0d pending, expected 0", exp_q.size()); end
    exp_q.delete();
    run_frame("afterrst", 1'b1, 2'd1, v, 2, 2, -1, -1, -1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_master16();
    test_slave64();
    test_crc_flip();
    test_manch();
    test_bad_delim();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
